// File: rtl/string_receiver_serial.sv
// 8N1 UART receiver that assembles MAX_CHARS characters into a string, first character in the MSB byte.
// Optional macro STRING_TERMINATOR_EN: a received CR ends the string early and pads unfilled bytes with spaces.
module string_receiver_serial #(
    parameter int unsigned MAX_CHARS     = 16,
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 19_200
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             rx,
    output logic                             done,
    output logic [MAX_CHARS*8-1:0]           string_out,
    output logic [$clog2(MAX_CHARS+1)-1:0]   char_count,
    output logic                             frame_err
);

    localparam int unsigned BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned TMR_W       = $clog2(BIT_CYCLES + 1);
    localparam int unsigned CNT_W       = $clog2(MAX_CHARS + 1);
    localparam int unsigned STR_W       = MAX_CHARS * 8;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_sync_q;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [STR_W-1:0]   string_q, string_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ferr_q, ferr_d;
    logic               brk_q, brk_d;
    logic               done_q, done_d;
    logic               tick_c;

    assign tick_c = (timer_q == '0);

    // Next-state, bit timing and string assembly
    always_comb begin
        state_d   = state_q;
        timer_d   = tick_c ? timer_q : timer_q - TMR_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        string_d  = string_q;
        count_d   = count_q;
        ferr_d    = ferr_q;
        brk_d     = brk_q;

        if (state_q != ST_WAIT && !enable) begin
            state_d = ST_WAIT;
            brk_d   = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (enable) begin
                        string_d = '0;
                        count_d  = '0;
                        ferr_d   = 1'b0;
                        brk_d    = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        timer_d = TMR_W'(HALF_CYCLES - 1);
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_c) begin
                        if (rx_sync_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            timer_d   = TMR_W'(BIT_CYCLES - 1);
                            bit_idx_d = 3'd0;
                            state_d   = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_c) begin
                        shift_d = {rx_sync_q, shift_q[7:1]};
                        timer_d = TMR_W'(BIT_CYCLES - 1);
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // After a bad stop bit, hold here until the line returns high
                    if (brk_q) begin
                        if (rx_sync_q) begin
                            brk_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else if (tick_c) begin
                        if (!rx_sync_q) begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
`ifdef STRING_TERMINATOR_EN
                        end else if (shift_q == 8'h0D) begin
                            for (int i = 0; i < int'(MAX_CHARS); i++) begin
                                if (CNT_W'(i) >= count_q) begin
                                    string_d[(int'(MAX_CHARS) - 1 - i)*8 +: 8] = 8'h20;
                                end
                            end
                            state_d = ST_DONE;
`endif
                        end else if (count_q < CNT_W'(MAX_CHARS)) begin
                            for (int i = 0; i < int'(MAX_CHARS); i++) begin
                                if (CNT_W'(i) == count_q) begin
                                    string_d[(int'(MAX_CHARS) - 1 - i)*8 +: 8] = shift_q;
                                end
                            end
                            count_d = count_q + CNT_W'(1);
                            state_d = (count_q == CNT_W'(MAX_CHARS - 1)) ? ST_DONE : ST_IDLE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end

        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with rx synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            string_q  <= '0;
            count_q   <= '0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            string_q  <= string_d;
            count_q   <= count_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            done_q    <= done_d;
        end
    end

    assign done       = done_q;
    assign string_out = string_q;
    assign char_count = count_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_string_receiver_serial.sv
// Scoreboard bench for string_receiver_serial at 10 clocks per bit; honours STRING_TERMINATOR_EN.
module tb_string_receiver_serial;

    localparam int unsigned MAXC = 16;
    localparam int unsigned BITC = 10;
    localparam int unsigned SW   = MAXC * 8;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          rx;
    logic          done;
    logic [SW-1:0] string_out;
    logic [CW-1:0] char_count;
    logic          frame_err;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [7:0]    exp_q[$];
    int            prev_cnt = 0;

    string_receiver_serial #(
        .MAX_CHARS    (MAXC),
        .CLK_FREQUENCY(1_000_000),
        .BAUD_RATE    (100_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rx        (rx),
        .done      (done),
        .string_out(string_out),
        .char_count(char_count),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        logic stored;
        stored = stop_ok;
`ifdef STRING_TERMINATOR_EN
        if (b == 8'h0D) stored = 1'b0;
`endif
        if (stored) exp_q.push_back(b);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_count(input int target, input string tag);
        int n;
        n = 0;
        while (int'(char_count) != target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, SW'(char_count), SW'(target));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, SW'(done), SW'(1));
    endtask

    // Each newly stored character is compared against the oldest expected byte
    always @(negedge clk) begin
        if (reset) begin
            prev_cnt = 0;
        end else begin
            if (int'(char_count) == prev_cnt + 1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_char", SW'(char_count), SW'(prev_cnt));
                end else begin
                    check("sb_byte", SW'(string_out[(int'(MAXC) - int'(char_count))*8 +: 8]),
                          SW'(exp_q.pop_front()));
                end
            end
            prev_cnt = int'(char_count);
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        rx     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_done", SW'(done), '0);
        check("rst_string", string_out, '0);
        check("rst_count", SW'(char_count), '0);
        check("rst_ferr", SW'(frame_err), '0);
        reset = 1'b0;

        // Full 16-character string
        enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) send_byte(8'(8'h41 + c), 1'b1);
        wait_count(16, "count_full");
        check("done_full", SW'(done), SW'(1));
        check("string_full", string_out, 128'h4142434445464748494A4B4C4D4E4F50);
        enable = 1'b0;
        @(negedge clk);
        check("done_drop", SW'(done), '0);
        check("count_hold", SW'(char_count), SW'(16));

        // Re-enable clears; glitch ignored
        enable = 1'b1;
        @(negedge clk);
        check("clr_string", string_out, '0);
        check("clr_count", SW'(char_count), '0);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_count", SW'(char_count), '0);
        send_byte(8'h5A, 1'b1);
        wait_count(1, "count_5a");
        check("byte0_5a", SW'(string_out[127:120]), SW'(8'h5A));
        check("ferr_clean", SW'(frame_err), '0);

        // Framing error then a good character
        send_byte(8'h33, 1'b0);
        repeat (5) @(negedge clk);
        check("ferr_set", SW'(frame_err), SW'(1));
        check("ferr_count", SW'(char_count), SW'(1));
        send_byte(8'h34, 1'b1);
        wait_count(2, "count_34");
        check("ferr_sticky", SW'(frame_err), SW'(1));

        // Drop enable mid-character
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("ferr_clr", SW'(frame_err), '0);
        check("clr_count2", SW'(char_count), '0);
        for (int c = 0; c < 5; c++) send_byte(8'(8'h61 + c), 1'b1);
        wait_count(5, "count5");
        rx = 1'b0;
        repeat (25) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("drop_done", SW'(done), '0);
        check("drop_count", SW'(char_count), SW'(5));
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("drop_count_held", SW'(char_count), SW'(5));
        enable = 1'b1;
        @(negedge clk);
        check("reen_count", SW'(char_count), '0);
        check("reen_string", string_out, '0);
        check("sb_drained_mid", SW'(exp_q.size()), '0);

        // CR handling
        repeat (5) @(negedge clk);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h0D, 1'b1);
`ifdef STRING_TERMINATOR_EN
        wait_done("cr_done");
        check("cr_string", string_out, {16'h4142, {14{8'h20}}});
        check("cr_count", SW'(char_count), SW'(2));
`else
        wait_count(3, "cr_count");
        check("cr_string", SW'(string_out[127:104]), SW'(24'h41420D));
        check("cr_done", SW'(done), '0);
`endif
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained_end", SW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
